// File: rtl/lrf_pkg.sv
// rtl/lrf_pkg.sv - shared line-buffer geometry defaults and counter sizing
package lrf_pkg;

  localparam int LRF_PIXELS_PER_BEAT = 16;
  localparam int LRF_PIXEL_WIDTH     = 8;
  localparam int LRF_IMAGE_DIM       = 512;
  localparam int LRF_DATA_WIDTH      = LRF_PIXEL_WIDTH * LRF_PIXELS_PER_BEAT;
  localparam int LRF_BEATS_PER_ROW   = LRF_IMAGE_DIM / LRF_PIXELS_PER_BEAT;

  // Counters never collapse to zero width, even for a one-beat row.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LRF_COL_W = cnt_width(LRF_BEATS_PER_ROW);
  localparam int LRF_ROW_W = cnt_width(LRF_IMAGE_DIM);

  // First row index that has two older rows stored above it.
  localparam int LRF_FIRST_STREAM_ROW = 2;

endpackage

// File: rtl/row_store.sv
// rtl/row_store.sv - one row of beats, registered read, read-before-write
module row_store #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  // Both accesses sample the old array, so a same-address read returns the prior row.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/row_window_ctrl.sv
// rtl/row_window_ctrl.sv - two-row line buffer emitting vertically aligned 3-row beats
module row_window_ctrl
  import lrf_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = LRF_PIXELS_PER_BEAT,
  parameter int PIXEL_WIDTH     = LRF_PIXEL_WIDTH,
  parameter int IMAGE_DIM       = LRF_IMAGE_DIM,
  parameter int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_top,
  output logic [DATA_WIDTH-1:0] out_mid,
  output logic [DATA_WIDTH-1:0] out_bot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_eof,
  output logic                  row_err
);

  localparam int BEATS_PER_ROW = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int COL_W         = cnt_width(BEATS_PER_ROW);
  localparam int ROW_W         = cnt_width(IMAGE_DIM);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMAGE_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(LRF_FIRST_STREAM_ROW);

  logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_eof_q, row_err_q;
  logic [DATA_WIDTH-1:0] bot_q;
  logic                  sel_q;

  logic                  accept;
  logic                  consume;
  logic                  col_at_last;
  logic                  row_at_last;
  logic [DATA_WIDTH-1:0] rd_data [2];

  assign in_ready    = ~out_valid_q | out_ready;
  assign accept      = in_valid & in_ready;
  assign consume     = out_valid_q & out_ready;
  assign col_at_last = (col_cnt_q == COL_LAST);
  assign row_at_last = (row_cnt_q == ROW_LAST);

  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      col_cnt_d = col_at_last ? '0 : col_cnt_q + 1'b1;
      if (col_at_last) begin
        row_cnt_d = row_at_last ? '0 : row_cnt_q + 1'b1;
      end
      // Priming rows are stored but produce nothing; an accept also covers a same-cycle consume.
      out_valid_d = (row_cnt_q >= ROW_FIRST);
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_eof_q   <= 1'b0;
      row_err_q   <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_last_q <= col_at_last;
        out_eof_q  <= col_at_last & row_at_last;
        if (in_last != col_at_last) begin
          row_err_q <= 1'b1;
        end
      end
    end
  end

  // Datapath only changes on accept, so it is frozen whenever the output is stalled.
  always_ff @(posedge clk) begin
    if (accept) begin
      bot_q <= in_data;
      sel_q <= row_cnt_q[0];
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_store
    row_store #(
      .DEPTH (BEATS_PER_ROW),
      .AW    (COL_W),
      .DW    (DATA_WIDTH)
    ) u_store (
      .clk     (clk),
      .wr_en   (accept & (row_cnt_q[0] == 1'(i))),
      .wr_addr (col_cnt_q),
      .wr_data (in_data),
      .rd_en   (accept),
      .rd_addr (col_cnt_q),
      .rd_data (rd_data[i])
    );
  end

  // The store being overwritten held row n-2; the other one holds row n-1.
  assign out_top   = sel_q ? rd_data[1] : rd_data[0];
  assign out_mid   = sel_q ? rd_data[0] : rd_data[1];
  assign out_bot   = bot_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_eof   = out_eof_q;
  assign row_err   = row_err_q;

endmodule
